letter_spawner: RTL and testbench

Parametrised spawn engine for the falling-letter typing game. It generates falling-letter spawn records: a character, a fall speed, a start column and a lane row. It replaces free-running per-field random taps with one internal LFSR, a level-scaled spawn interval and a valid/ready handshake. It sits between the game controller, which sets `enable`/`level`, and the sprite table, which consumes spawn records.

---
 rtl/letter_spawner_pkg.sv | 25 ++
 rtl/letter_spawner_if.sv | 39 +++
 rtl/letter_spawner_lfsr16.sv | 27 ++
 rtl/letter_spawner.sv | 140 ++++++++++++++
 tb/tb_letter_spawner.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/letter_spawner_pkg.sv
// Shared constants, FSM state type and LFSR helpers for the letter spawn engine.
// Consumed by letter_spawner and lfsr16.
package letter_spawner_pkg;

    localparam logic [7:0]  ASCII_A   = 8'd97;
    localparam int unsigned ALPHABET  = 26;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        OFFER = 2'd2
    } state_e;

    // Right-shifting Galois step: the bit shifted out selects whether the taps are applied.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero Galois register never leaves zero, so a zero seed becomes 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/letter_spawner_if.sv
// Spawn-record bus between the game controller / sprite table and letter_spawner.
// master = the spawner (record producer), slave = controller plus consumer side.
interface letter_spawner_if;

    logic        enable;
    logic [1:0]  level;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [7:0]  spawn_ch;
    logic [3:0]  spawn_speed;
    logic [8:0]  spawn_x;
    logic [9:0]  spawn_y;
    logic [15:0] spawn_count;

    modport master (
        input  enable,
        input  level,
        input  spawn_ready,
        output spawn_valid,
        output spawn_ch,
        output spawn_speed,
        output spawn_x,
        output spawn_y,
        output spawn_count
    );

    modport slave (
        output enable,
        output level,
        output spawn_ready,
        input  spawn_valid,
        input  spawn_ch,
        input  spawn_speed,
        input  spawn_x,
        input  spawn_y,
        input  spawn_count
    );

endinterface

// File: rtl/letter_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16'hB400); advances on every clock edge.
// Asynchronous active-high reset loads SEED, with zero replaced by 1.
module lfsr16
    import letter_spawner_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    localparam logic [15:0] RESET_VAL = seed_fix(SEED);

    logic [15:0] state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/letter_spawner.sv
// Spawn engine: level-scaled interval counter, IDLE/DRAW/OFFER FSM and valid/ready record output.
// Optional feature macro LETTER_SPAWNER_NO_REPEAT_EN: bump lane/letter that repeat the last accepted record.
module letter_spawner
    import letter_spawner_pkg::*;
#(
    parameter int unsigned LANES      = 70,
    parameter int unsigned LANE_PITCH = 9,
    parameter int unsigned SPEED_MAX  = 4,
    parameter int unsigned INTERVAL   = 25_000_000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    letter_spawner_if.master  sp
);

    localparam logic [31:0] CNT_RESET = 32'(INTERVAL - 32'd1);
    localparam logic [7:0]  ASCII_Z   = 8'(ASCII_A + 8'(ALPHABET - 1));

    logic [15:0] lfsr;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    state_e      state_q;
    logic [31:0] cnt_q;
    logic        valid_q;
    logic [7:0]  ch_q;
    logic [3:0]  speed_q;
    logic [9:0]  y_q;
    logic [15:0] count_q;

    logic [9:0]  lane_raw_d;
    logic [7:0]  ch_raw_d;
    logic [9:0]  lane_d;
    logic [7:0]  ch_d;
    logic [3:0]  speed_d;
    logic [9:0]  y_d;
    logic [31:0] shifted_d;
    logic [31:0] reload_d;

`ifdef LETTER_SPAWNER_NO_REPEAT_EN
    logic [9:0]  cur_lane_q;
    logic [9:0]  last_lane_q;
    logic [7:0]  last_ch_q;
`endif

    always_comb begin
        lane_raw_d = 10'(32'(lfsr[11:0]) % LANES);
        ch_raw_d   = ASCII_A + 8'(32'(lfsr[7:0]) % ALPHABET);
        speed_d    = 4'd1 + 4'(32'(lfsr[15:12]) % SPEED_MAX);
        lane_d     = lane_raw_d;
        ch_d       = ch_raw_d;
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
        // Lane and letter are checked independently against the last accepted record.
        if (lane_raw_d == last_lane_q) begin
            lane_d = (lane_raw_d == 10'(LANES - 1)) ? 10'd0 : lane_raw_d + 10'd1;
        end
        if (ch_raw_d == last_ch_q) begin
            ch_d = (ch_raw_d == ASCII_Z) ? ASCII_A : ch_raw_d + 8'd1;
        end
`endif
        y_d = 10'(32'(lane_d) * LANE_PITCH);
    end

    // Reload is max(INTERVAL >> level, 1) - 1; a shift down to zero clamps to an immediate draw.
    always_comb begin
        shifted_d = 32'(INTERVAL) >> sp.level;
        reload_d  = (shifted_d == 32'd0) ? 32'd0 : shifted_d - 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_RESET;
            valid_q     <= 1'b0;
            ch_q        <= ASCII_A;
            speed_q     <= 4'd1;
            y_q         <= 10'd0;
            count_q     <= 16'd0;
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
            cur_lane_q  <= 10'd0;
            last_lane_q <= 10'd0;
            last_ch_q   <= ASCII_A;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sp.enable) begin
                        if (cnt_q == 32'd0) begin
                            state_q <= DRAW;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                end
                DRAW: begin
                    ch_q       <= ch_d;
                    speed_q    <= speed_d;
                    y_q        <= y_d;
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
                    cur_lane_q <= lane_d;
`endif
                    valid_q    <= 1'b1;
                    state_q    <= OFFER;
                end
                OFFER: begin
                    // enable is ignored here: an offered record stays up until accepted.
                    if (valid_q && sp.spawn_ready) begin
                        valid_q     <= 1'b0;
                        count_q     <= count_q + 16'd1;
                        cnt_q       <= reload_d;
                        state_q     <= IDLE;
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
                        last_lane_q <= cur_lane_q;
                        last_ch_q   <= ch_q;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sp.spawn_valid = valid_q;
    assign sp.spawn_ch    = ch_q;
    assign sp.spawn_speed = speed_q;
    assign sp.spawn_x     = 9'd0;
    assign sp.spawn_y     = y_q;
    assign sp.spawn_count = count_q;

endmodule

// File: tb/tb_letter_spawner.sv
// Scoreboard bench for letter_spawner: a phase-level reference model queues expected records,
// a negedge monitor checks every offered record, its timing and the accept counter.
`timescale 1ns/1ps
module tb_letter_spawner;

    localparam int unsigned INTERVAL  = 6;
    localparam int unsigned LANES     = 70;
    localparam int unsigned PITCH     = 9;
    localparam int unsigned SPEED_MAX = 4;
    localparam logic [15:0] SEED      = 16'hACE1;

    localparam int M_WAIT  = 0;
    localparam int M_DRAW  = 1;
    localparam int M_OFFER = 2;

    typedef struct {
        int          rise_edge;
        int unsigned lane;
        logic [7:0]  ch;
        logic [3:0]  speed;
        logic [9:0]  y;
        logic [15:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    letter_spawner_if sp();

    letter_spawner #(
        .LANES      (LANES),
        .LANE_PITCH (PITCH),
        .SPEED_MAX  (SPEED_MAX),
        .INTERVAL   (INTERVAL),
        .SEED       (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sp  (sp.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rec_t        sb_q[$];
    int          m_phase;
    int          m_wait;
    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;
    int unsigned m_cur_lane;
    logic [7:0]  m_cur_ch;
    int unsigned m_last_lane;
    logic [7:0]  m_last_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_reset();
        m_phase     = M_WAIT;
        m_wait      = int'(INTERVAL);
        m_lfsr      = SEED;
        m_cnt       = 16'd0;
        m_last_lane = 0;
        m_last_ch   = 8'd97;
        m_cur_lane  = 0;
        m_cur_ch    = 8'd97;
        cyc         = 0;
        sb_q.delete();
    endtask

    // Called once per rising edge with the inputs the DUT samples at that edge.
    task automatic model_step();
        rec_t        r;
        int unsigned sh;
        cyc++;
        case (m_phase)
            M_WAIT: begin
                if (sp.enable) begin
                    m_wait--;
                    if (m_wait == 0) m_phase = M_DRAW;
                end
            end
            M_DRAW: begin
                r.lane  = 32'(m_lfsr[11:0]) % LANES;
                r.ch    = 8'(32'd97 + 32'(m_lfsr[7:0]) % 32'd26);
                r.speed = 4'(32'd1 + 32'(m_lfsr[15:12]) % SPEED_MAX);
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
                if (r.lane == m_last_lane) r.lane = (r.lane + 1) % LANES;
                if (r.ch == m_last_ch) r.ch = (r.ch == 8'd122) ? 8'd97 : r.ch + 8'd1;
`endif
                r.y         = 10'(r.lane * PITCH);
                r.rise_edge = cyc;
                r.cnt       = m_cnt;
                sb_q.push_back(r);
                m_cur_lane  = r.lane;
                m_cur_ch    = r.ch;
                m_phase     = M_OFFER;
            end
            default: begin
                if (sp.spawn_ready) begin
                    m_cnt       = m_cnt + 16'd1;
                    m_last_lane = m_cur_lane;
                    m_last_ch   = m_cur_ch;
                    sh          = INTERVAL >> sp.level;
                    m_wait      = (sh == 0) ? 1 : int'(sh);
                    m_phase     = M_WAIT;
                end
            end
        endcase
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic        prev_v  = 1'b0;
    logic        prev_hs = 1'b0;
    logic [9:0]  mon_y   = 10'd0;
    logic [7:0]  mon_ch  = 8'd97;
    rec_t        e;

    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
            mon_y   = 10'd0;
            mon_ch  = 8'd97;
        end else begin
            if (prev_v && !prev_hs) check("valid_held", 32'(sp.spawn_valid), 32'd1);
            if (sp.spawn_valid) begin
                check("record_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q[0];
                    if (!prev_v || prev_hs) begin
                        check("rise_edge", 32'(cyc), 32'(e.rise_edge));
                        check("ch_range", 32'(sp.spawn_ch >= 8'd97 && sp.spawn_ch <= 8'd122), 32'd1);
                        check("speed_range", 32'(sp.spawn_speed >= 4'd1 && sp.spawn_speed <= 4'd4), 32'd1);
                        check("y_grid", 32'((sp.spawn_y % 10'd9) == 10'd0 && sp.spawn_y <= 10'd621), 32'd1);
`ifdef LETTER_SPAWNER_NO_REPEAT_EN
                        check("lane_no_repeat", 32'(sp.spawn_y != mon_y), 32'd1);
                        check("ch_no_repeat", 32'(sp.spawn_ch != mon_ch), 32'd1);
`endif
                    end
                    check("spawn_ch", 32'(sp.spawn_ch), 32'(e.ch));
                    check("spawn_speed", 32'(sp.spawn_speed), 32'(e.speed));
                    check("spawn_x", 32'(sp.spawn_x), 32'd0);
                    check("spawn_y", 32'(sp.spawn_y), 32'(e.y));
                    check("spawn_count", 32'(sp.spawn_count), 32'(e.cnt));
                    if (sp.spawn_ready) begin
                        mon_y  = sp.spawn_y;
                        mon_ch = sp.spawn_ch;
                        void'(sb_q.pop_front());
                    end
                end
            end
            prev_v  = sp.spawn_valid;
            prev_hs = sp.spawn_valid && sp.spawn_ready;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit aborted;
        sp.enable      = 1'b0;
        sp.level       = 2'd0;
        sp.spawn_ready = 1'b0;
        rst            = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(sp.spawn_valid), 32'd0);
        check("rst_ch", 32'(sp.spawn_ch), 32'd97);
        check("rst_speed", 32'(sp.spawn_speed), 32'd1);
        check("rst_x", 32'(sp.spawn_x), 32'd0);
        check("rst_y", 32'(sp.spawn_y), 32'd0);
        check("rst_count", 32'(sp.spawn_count), 32'd0);
        #1 rst = 1'b0;
        sp.enable      = 1'b1;
        sp.spawn_ready = 1'b1;

        // Steady rate: period INTERVAL+2 = 8, accepts at edges 8, 16, ..., 96.
        repeat (100) step();
        check("count_after_100", 32'(sp.spawn_count), 32'd12);

        // Level scaling: 6>>1=3, 6>>2=1, 6>>3=0 clamps to 1.
        for (int lvl = 1; lvl < 4; lvl++) begin
            sp.level = 2'(lvl);
            repeat (60) step();
        end

        // Backpressure: an offer sits with ready low for well over 20 cycles.
        sp.level       = 2'd0;
        sp.spawn_ready = 1'b0;
        repeat (40) step();
        sp.spawn_ready = 1'b1;
        repeat (20) step();

        // Random enable / ready / level.
        repeat (3000) begin
            step();
            sp.enable      = ($urandom_range(0, 9) < 8);
            sp.spawn_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) sp.level = 2'($urandom_range(0, 3));
        end

        // Asynchronous abort while a record is offered.
        sp.enable      = 1'b1;
        sp.spawn_ready = 1'b0;
        aborted        = 1'b0;
        for (int i = 0; i < 200 && !aborted; i++) begin
            step();
            if (m_phase == M_OFFER) begin
                check("abort_pre_valid", 32'(sp.spawn_valid), 32'd1);
                #1 rst = 1'b1;
                #1;
                check("abort_valid", 32'(sp.spawn_valid), 32'd0);
                check("abort_count", 32'(sp.spawn_count), 32'd0);
                aborted = 1'b1;
            end
        end
        check("abort_reached", 32'(aborted), 32'd1);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        #1 rst = 1'b0;
        sp.spawn_ready = 1'b1;

        // Range sweep: ~10,000 spawns at the 3-cycle period.
        sp.level = 2'd3;
        repeat (30000) step();

        // Drain: no new draws with enable low; everything queued must have been seen.
        sp.enable = 1'b0;
        repeat (20) step();
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("final_count", 32'(sp.spawn_count), 32'(m_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
